// File: rtl/aes_128_inv_mixcol.sv
// ============================================================================
// Module  : aes_128_inv_mixcol
// Brief   : Column-serial AES InvMixColumns engine, COL_PER_CYC columns/clock.
//           Optional pass-through port enabled by AES_INV_MIXCOL_BYPASS_EN.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module aes_128_inv_mixcol #(
   parameter int COL_PER_CYC = 1
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         en,
`ifdef AES_INV_MIXCOL_BYPASS_EN
   input  logic         bypass,
`endif
   input  logic [127:0] in_data,
   output logic [127:0] out_data,
   output logic         busy,
   output logic         done
);

   localparam int N     = (COL_PER_CYC > 0) ? (4 / COL_PER_CYC) : 1;
   localparam int CNT_W = (N > 1) ? $clog2(N) : 1;
   localparam logic [CNT_W-1:0] C_LAST = CNT_W'(N - 1);

   generate
      if (COL_PER_CYC != 1 && COL_PER_CYC != 2 && COL_PER_CYC != 4) begin : g_bad_col_per_cyc
         $error("aes_128_inv_mixcol: COL_PER_CYC must be 1, 2 or 4");
      end
   endgenerate

   typedef enum logic [0:0] {
      S_IDLE = 1'b0,
      S_RUN  = 1'b1
   } state_t;

   function automatic logic [7:0] xtime(input logic [7:0] b);
      return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
   endfunction

   // Each output byte combines the 09/0b/0d/0e multiples built from x2, x4, x8.
   function automatic logic [31:0] inv_mix_col(input logic [31:0] col);
      logic [7:0] a  [4];
      logic [7:0] m9 [4];
      logic [7:0] mb [4];
      logic [7:0] md [4];
      logic [7:0] me [4];
      logic [7:0] x2, x4, x8;
      for (int i = 0; i < 4; i++) begin
         a[i]  = col[31-8*i -: 8];
         x2    = xtime(a[i]);
         x4    = xtime(x2);
         x8    = xtime(x4);
         m9[i] = x8 ^ a[i];
         mb[i] = x8 ^ x2 ^ a[i];
         md[i] = x8 ^ x4 ^ a[i];
         me[i] = x8 ^ x4 ^ x2;
      end
      return {me[0] ^ mb[1] ^ md[2] ^ m9[3],
              m9[0] ^ me[1] ^ mb[2] ^ md[3],
              md[0] ^ m9[1] ^ me[2] ^ mb[3],
              mb[0] ^ md[1] ^ m9[2] ^ me[3]};
   endfunction

   state_t             state_q, state_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic [127:0]       work_q, work_d;
   logic [127:0]       out_data_q, out_data_d;
   logic               done_q, done_d;
   logic               xform_en;
   logic [31:0]        col_inv [4];

`ifdef AES_INV_MIXCOL_BYPASS_EN
   logic               bypass_q, bypass_d;
   assign xform_en = ~bypass_q;
`else
   assign xform_en = 1'b1;
`endif

   generate
      for (genvar c = 0; c < 4; c++) begin : g_col
         assign col_inv[c] = inv_mix_col(work_q[127-32*c -: 32]);
      end
   endgenerate

   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      work_d     = work_q;
      out_data_d = out_data_q;
      done_d     = 1'b0;
`ifdef AES_INV_MIXCOL_BYPASS_EN
      bypass_d   = bypass_q;
`endif
      case (state_q)
         S_IDLE: begin
            if (en) begin
               work_d  = in_data;
               cnt_d   = '0;
               state_d = S_RUN;
`ifdef AES_INV_MIXCOL_BYPASS_EN
               bypass_d = bypass;
`endif
            end
         end
         S_RUN: begin
            for (int c = 0; c < 4; c++) begin
               if (xform_en && ((c / COL_PER_CYC) == int'(cnt_q))) begin
                  work_d[127-32*c -: 32] = col_inv[c];
               end
            end
            cnt_d = cnt_q + CNT_W'(1);
            // Final group lands straight in out_data so the result is visible with done.
            if (cnt_q == C_LAST) begin
               out_data_d = work_d;
               done_d     = 1'b1;
               cnt_d      = '0;
               state_d    = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= S_IDLE;
         cnt_q      <= '0;
         work_q     <= '0;
         out_data_q <= '0;
         done_q     <= 1'b0;
`ifdef AES_INV_MIXCOL_BYPASS_EN
         bypass_q   <= 1'b0;
`endif
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         work_q     <= work_d;
         out_data_q <= out_data_d;
         done_q     <= done_d;
`ifdef AES_INV_MIXCOL_BYPASS_EN
         bypass_q   <= bypass_d;
`endif
      end
   end

   assign out_data = out_data_q;
   assign busy     = (state_q == S_RUN);
   assign done     = done_q;

endmodule

`default_nettype wire
